// File: rtl/scp_breach_ctrl_param.sv
// Parametrised breach/containment controller: probe, sequential attack of N_SUBSYS
// targets, lockdown, timed containment. Optional CHEAT phase enabled by SCP_CHEAT_EN.
module scp_breach_ctrl_param #(
    parameter int N_SUBSYS  = 3,
    parameter int TIMER_W   = 8,
    parameter int PROBE_T   = 4,
    parameter int ATTACK_T  = 5,
    parameter int CONTAIN_T = 6,
    parameter int CHEAT_T   = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                green,
    input  logic                yellow,
    input  logic                red,
    output logic [N_SUBSYS-1:0] a_subsys,
    output logic [2:0]          state,
    output logic [TIMER_W-1:0]  timer,
    output logic                cheat_out
);
    localparam int IDX_W = (N_SUBSYS > 1) ? $clog2(N_SUBSYS) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PROBE    = 3'd1;
    localparam logic [2:0] S_ATTACK   = 3'd2;
    localparam logic [2:0] S_LOCKDOWN = 3'd3;
    localparam logic [2:0] S_CONTAIN  = 3'd4;
    localparam logic [2:0] S_CHEAT    = 3'd5;

    localparam logic [TIMER_W-1:0]  TMAX         = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0]  PROBE_LAST   = TIMER_W'(PROBE_T - 1);
    localparam logic [TIMER_W-1:0]  ATTACK_LAST  = TIMER_W'(ATTACK_T - 1);
    localparam logic [TIMER_W-1:0]  CONTAIN_LAST = TIMER_W'(CONTAIN_T - 1);
    localparam logic [TIMER_W-1:0]  CHEAT_LAST   = TIMER_W'(CHEAT_T - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST     = IDX_W'(N_SUBSYS - 1);
    localparam logic [N_SUBSYS-1:0] VEC_ONE      = N_SUBSYS'(1);

    logic [2:0]          state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d, timer_inc_s;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_SUBSYS-1:0] a_subsys_q, a_subsys_d;
    logic                cheat_q, cheat_d;
    logic                adv_s, hold_s;

    assign timer_inc_s = (timer_q == TMAX) ? timer_q : timer_q + TIMER_W'(1);

    // State register: all outputs come straight from flops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            timer_q    <= {TIMER_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            a_subsys_q <= {N_SUBSYS{1'b0}};
            cheat_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            a_subsys_q <= a_subsys_d;
            cheat_q    <= cheat_d;
        end
    end

    // Next-state, index and timer; level priority red > yellow > green
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        adv_s   = 1'b0;
        hold_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (red)        state_d = S_CONTAIN;
                else if (yellow) state_d = S_IDLE;
                else if (green) state_d = S_PROBE;
                else            state_d = S_IDLE;
            end
            S_PROBE: begin
                if (red)        state_d = S_CONTAIN;
                else if (yellow) state_d = S_IDLE;
                else if (timer_q == PROBE_LAST) begin
                    state_d = S_ATTACK;
                    idx_d   = {IDX_W{1'b0}};
                end else        state_d = S_PROBE;
            end
            S_ATTACK: begin
                if (red) begin
`ifdef SCP_CHEAT_EN
                    if (idx_q == IDX_LAST) state_d = S_CHEAT;
                    else                   state_d = S_CONTAIN;
`else
                    state_d = S_CONTAIN;
`endif
                end else if (yellow) begin
                    hold_s = 1'b1;
                end else if (timer_q == ATTACK_LAST) begin
                    if (idx_q == IDX_LAST) state_d = S_LOCKDOWN;
                    else begin
                        idx_d = idx_q + IDX_W'(1);
                        adv_s = 1'b1;
                    end
                end else begin
                    state_d = S_ATTACK;
                end
            end
            S_LOCKDOWN: begin
                if (red) state_d = S_CONTAIN;
                else     state_d = S_LOCKDOWN;
            end
            S_CONTAIN: begin
                if (timer_q == CONTAIN_LAST) begin
                    state_d = S_IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end else state_d = S_CONTAIN;
            end
            S_CHEAT: begin
                if (timer_q == CHEAT_LAST) state_d = S_LOCKDOWN;
                else                       state_d = S_CHEAT;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase

        if ((state_d != state_q) || adv_s) timer_d = {TIMER_W{1'b0}};
        else if (hold_s)                   timer_d = timer_q;
        else                               timer_d = timer_inc_s;
    end

    // Output decode from the upcoming state so outputs track the transition edge
    always_comb begin
        a_subsys_d = {N_SUBSYS{1'b0}};
        case (state_d)
            S_ATTACK:            a_subsys_d = VEC_ONE << idx_d;
            S_LOCKDOWN, S_CHEAT: a_subsys_d = {N_SUBSYS{1'b1}};
            default:             a_subsys_d = {N_SUBSYS{1'b0}};
        endcase
`ifdef SCP_CHEAT_EN
        cheat_d = (state_d == S_CHEAT);
`else
        cheat_d = 1'b0;
`endif
    end

    assign a_subsys  = a_subsys_q;
    assign state     = state_q;
    assign timer     = timer_q;
    assign cheat_out = cheat_q;
endmodule

// File: tb/tb_scp_breach_ctrl_param.sv
// Directed bench for scp_breach_ctrl_param: default instance plus a
// one-target, 2-bit-timer instance for saturation checks.
module tb_scp_breach_ctrl_param;
    logic clock = 1'b0;
    logic reset_n;
    logic green, yellow, red;
    logic green2, yellow2, red2;
    logic [2:0] a_subsys;
    logic [2:0] state;
    logic [7:0] timer;
    logic       cheat_out;
    logic [0:0] a2;
    logic [2:0] state2;
    logic [1:0] timer2;
    logic       cheat2;
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    scp_breach_ctrl_param dut (
        .clock(clock), .reset_n(reset_n), .green(green), .yellow(yellow), .red(red),
        .a_subsys(a_subsys), .state(state), .timer(timer), .cheat_out(cheat_out)
    );

    scp_breach_ctrl_param #(
        .N_SUBSYS(1), .TIMER_W(2), .PROBE_T(2), .ATTACK_T(3), .CONTAIN_T(3), .CHEAT_T(3)
    ) dut2 (
        .clock(clock), .reset_n(reset_n), .green(green2), .yellow(yellow2), .red(red2),
        .a_subsys(a2), .state(state2), .timer(timer2), .cheat_out(cheat2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [2:0] st, input logic [7:0] tm,
                        input logic [2:0] av);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".timer"}, 32'(timer), 32'(tm));
        chk({tag, ".a_subsys"}, 32'(a_subsys), 32'(av));
    endtask

    initial begin
        reset_n = 1'b0;
        green = 1'b0; yellow = 1'b0; red = 1'b0;
        green2 = 1'b0; yellow2 = 1'b0; red2 = 1'b0;
        step(3);
        chk1("reset", 3'd0, 8'd0, 3'b000);
        chk("reset.cheat", 32'(cheat_out), 32'd0);
        reset_n = 1'b1;

        // Full escalation with green held
        green = 1'b1;
        step(1); chk1("t1.probe0", 3'd1, 8'd0, 3'b000);
        step(3); chk1("t1.probe3", 3'd1, 8'd3, 3'b000);
        step(1); chk1("t1.atk0", 3'd2, 8'd0, 3'b001);
        step(4); chk1("t1.atk0_t4", 3'd2, 8'd4, 3'b001);
        step(1); chk1("t1.atk1", 3'd2, 8'd0, 3'b010);
        step(5); chk1("t1.atk2", 3'd2, 8'd0, 3'b100);
        step(5); chk1("t1.lock", 3'd3, 8'd0, 3'b111);
        step(2); chk1("t1.lock_t2", 3'd3, 8'd2, 3'b111);
        green = 1'b0; red = 1'b1;
        step(1); chk1("t1.contain", 3'd4, 8'd0, 3'b000);
        step(5); chk1("t1.contain_t5", 3'd4, 8'd5, 3'b000);
        red = 1'b0;
        step(1); chk1("t1.idle", 3'd0, 8'd0, 3'b000);

        // Pause in ATTACK with yellow, then resume
        green = 1'b1;
        step(5); chk1("t2.atk0", 3'd2, 8'd0, 3'b001);
        step(7); chk1("t2.atk1_t2", 3'd2, 8'd2, 3'b010);
        green = 1'b0; yellow = 1'b1;
        step(7); chk1("t2.paused", 3'd2, 8'd2, 3'b010);
        yellow = 1'b0; green = 1'b1;
        step(2); chk1("t2.resume_t4", 3'd2, 8'd4, 3'b010);
        step(1); chk1("t2.atk2", 3'd2, 8'd0, 3'b100);

        // Red on the last target: CONTAIN in the default build, cheat stays low
        green = 1'b0; red = 1'b1;
        step(1); chk1("t5.contain", 3'd4, 8'd0, 3'b000);
        chk("t5.cheat", 32'(cheat_out), 32'd0);
        red = 1'b0;
        step(6); chk1("t5.idle", 3'd0, 8'd0, 3'b000);

        // green+red together in PROBE, red held through CONTAIN
        green = 1'b1;
        step(2); chk1("t3.probe1", 3'd1, 8'd1, 3'b000);
        red = 1'b1;
        step(1); chk1("t3.contain", 3'd4, 8'd0, 3'b000);
        step(5); chk1("t3.contain_t5", 3'd4, 8'd5, 3'b000);
        red = 1'b0; green = 1'b0;
        step(1); chk1("t3.idle", 3'd0, 8'd0, 3'b000);

        // Yellow abort in PROBE, then asynchronous reset mid-ATTACK
        green = 1'b1;
        step(3); chk1("t4.probe2", 3'd1, 8'd2, 3'b000);
        yellow = 1'b1;
        step(1); chk1("t4.abort", 3'd0, 8'd0, 3'b000);
        yellow = 1'b0;
        step(5); chk1("t4.atk0", 3'd2, 8'd0, 3'b001);
        step(3);
        reset_n = 1'b0;
        #1;
        chk1("t4.async_rst", 3'd0, 8'd0, 3'b000);
        chk("t4.async_cheat", 32'(cheat_out), 32'd0);
        step(1);
        reset_n = 1'b1;
        step(1); chk1("t4.restart", 3'd1, 8'd0, 3'b000);

        // Single-target instance with 2-bit saturating timer
        green = 1'b0;
        green2 = 1'b1;
        step(1); chk("t6.probe", 32'(state2), 32'd1);
        step(2);
        chk("t6.atk.state", 32'(state2), 32'd2);
        chk("t6.atk.a", 32'(a2), 32'd1);
        chk("t6.atk.timer", 32'(timer2), 32'd0);
        step(2); chk("t6.atk_t2", 32'(timer2), 32'd2);
        step(1);
        chk("t6.lock.state", 32'(state2), 32'd3);
        chk("t6.lock.a", 32'(a2), 32'd1);
        chk("t6.lock.timer", 32'(timer2), 32'd0);
        step(5);
        chk("t6.sat.timer", 32'(timer2), 32'd3);
        chk("t6.sat.state", 32'(state2), 32'd3);
        chk("t6.cheat", 32'(cheat2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
